wordcopy_pipe: RTL and testbench
================================

// Module: wordcopy_pipe
// PURPOSE
//  Next-generation Avalon-MM word-copy accelerator. Software programs dest, src and count over the slave port; the block moves words from src to dest through its master port.
//  Reads are pipelined with up to FIFO_DEPTH words outstanding, buffered in an internal FIFO, then written out.
//  Adds a fill mode, a non-blocking status register and an interrupt. Sits on the system interconnect beside the CPU and SDRAM.
// PARAMETERS
//  DATA_W      32  data width of slave and master ports; address step = DATA_W/8 bytes
//  ADDR_W      32  master address width
//  FIFO_DEPTH  8   read-data FIFO depth, also the max outstanding reads (power of 2, >=2)
// PORTS
//  clk                   in   1       clock, all state on rising edge
//  rst_n                 in   1       asynchronous active-low reset
//  slave_address         in   4       word offset: 0 CTRL, 1 DEST, 2 SRC, 3 COUNT, 4 STATUS, 5 FILL, 6 IRQEN
//  slave_read            in   1       slave read strobe
//  slave_write           in   1       slave write strobe
//  slave_writedata       in   DATA_W  slave write data
//  slave_readdata        out  DATA_W  slave read data, valid while slave_read=1 and slave_waitrequest=0
//  slave_waitrequest     out  1       stall slave access
//  master_address        out  ADDR_W  byte address of current command
//  master_read           out  1       read command
//  master_write          out  1       write command
//  master_writedata      out  DATA_W  write data
//  master_waitrequest    in   1       interconnect stall; hold command stable while 1
//  master_readdata       in   DATA_W  returned read data
//  master_readdatavalid  in   1       master_readdata valid this cycle
//  irq                   out  1       STATUS.done & IRQEN[0]
// BEHAVIOUR
//  Reset: outputs 0 except slave_waitrequest=1 while rst_n=0; all registers 0; FIFO empty; state IDLE.
//  Register writes (DEST/SRC/COUNT/FILL/IRQEN) take effect at the same edge. They are ignored while busy.
//  Write CTRL in IDLE: latch writedata into CTRL; mode=CTRL[0] (0 copy, 1 fill); clear done; go RUN next edge. Write CTRL while busy: ignored.
//  Read CTRL: slave_waitrequest=1 while busy; then 0, slave_readdata=CTRL. Waits ≥1 cycle after a start.
//  Read STATUS: never stalls. Returns {..,done[1],busy[0]}. Write STATUS with bit1=1 clears done.
//  Reads of other offsets return the register value with zero wait; unused offsets read 0.
//  Internal counters, loaded at start: rd_addr=SRC, wr_addr=DEST, rd_left=COUNT, wr_left=COUNT, inflight=0.
//  Read issue (copy mode): allowed when rd_left>0 and inflight+fifo_count<FIFO_DEPTH.
//   On acceptance (master_read & !master_waitrequest): rd_addr += DATA_W/8, rd_left--, inflight++.
//  readdatavalid: push into FIFO, inflight--. Overflow cannot occur by construction; the bench asserts on it.
//  Write issue: allowed when wr_left>0 and (fill mode or FIFO non-empty). Data = FILL (fill) or FIFO head.
//   On acceptance: pop (copy), wr_addr += DATA_W/8, wr_left--.
//  Master arbitration: one command per cycle. An eligible write beats an eligible read.
//   Once asserted, a command and its address/data are held unchanged until accepted. No switching while stalled.
//  Push and pop in the same cycle: fifo_count is unchanged.
//  Address arithmetic wraps modulo 2^ADDR_W. No error is flagged.
//  FSM states:
//   IDLE: waits for a CTRL write.
//   RUN: issues commands; when rd_left==0 (always true in fill mode) go to DRAIN.
//   DRAIN: writes only; when wr_left==0 and no command pending go to DONE.
//   DONE: one cycle; set done=1, busy=0; go to IDLE.
//  busy = state!=IDLE.
//  COUNT=0: RUN -> DRAIN -> DONE with no master traffic; done after 3 cycles.
//  Reset mid-transfer: abort immediately. Commands drop, FIFO is emptied, and late readdatavalid after reset is ignored.
// TESTING
//  1 Copy: DEST=0x12, SRC=0x13, COUNT=3, CTRL=0xAA; readdata 0x25,0x26,0x27 returned with gaps. Expect writes 0x25@0x12, 0x26@0x16, 0x27@0x1A; CTRL read stalls, then returns 0xAA.
//  2 Pipelining: COUNT=12, readdatavalid 4 cycles after each read. Expect ≤FIFO_DEPTH reads outstanding and no FIFO overflow; data order preserved.
//  3 Fill: FILL=0xDEADBEEF, DEST=0x100, COUNT=4, CTRL=1. Expect 4 writes to 0x100..0x10C with no master_read asserted.
//  4 Backpressure: master_waitrequest=1 for 5 cycles mid-copy. Expect command, address and data held stable; no words lost or duplicated.
//  5 Status/irq: IRQEN=1, COUNT=0, start. Expect STATUS=2 and irq=1 within 3 cycles; STATUS write 2 clears done and irq.
//  6 rst_n=0 during copy. Expect master_read/write=0 immediately; state IDLE and STATUS=0 after release.

Source files
------------

// File: rtl/wordcopy_pipe.sv
// Avalon-MM word-copy/fill engine: slave register file, pipelined master reads
// buffered in a small FIFO, then streamed back out as master writes.
module wordcopy_pipe #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        slave_address,
    input  logic              slave_read,
    input  logic              slave_write,
    input  logic [DATA_W-1:0] slave_writedata,
    output logic [DATA_W-1:0] slave_readdata,
    output logic              slave_waitrequest,
    output logic [ADDR_W-1:0] master_address,
    output logic              master_read,
    output logic              master_write,
    output logic [DATA_W-1:0] master_writedata,
    input  logic              master_waitrequest,
    input  logic [DATA_W-1:0] master_readdata,
    input  logic              master_readdatavalid,
    output logic              irq
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(DATA_W / 8);

    localparam logic [3:0] A_CTRL   = 4'd0;
    localparam logic [3:0] A_DEST   = 4'd1;
    localparam logic [3:0] A_SRC    = 4'd2;
    localparam logic [3:0] A_COUNT  = 4'd3;
    localparam logic [3:0] A_STATUS = 4'd4;
    localparam logic [3:0] A_FILL   = 4'd5;
    localparam logic [3:0] A_IRQEN  = 4'd6;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] ctrl, dest, src, count, fill, irqen, irqen_nxt;
    logic              done, done_nxt;
    logic [ADDR_W-1:0] rd_addr, wr_addr;
    logic [DATA_W-1:0] rd_left, wr_left;
    logic [CNT_W-1:0]  inflight, fifo_count;
    logic [PTR_W-1:0]  fifo_rd_ptr, fifo_wr_ptr;
    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];

    logic busy, mode_fill, start, cfg_wr, cmd_pend;
    logic rd_acc, wr_acc, push, pop, can_wr, can_rd, issue_wr, issue_rd;

    assign busy      = (state != S_IDLE);
    assign mode_fill = ctrl[0];
    assign start     = slave_write && (slave_address == A_CTRL) && (state == S_IDLE);
    assign cfg_wr    = slave_write && !busy;
    assign cmd_pend  = master_read || master_write;
    assign rd_acc    = master_read && !master_waitrequest;
    assign wr_acc    = master_write && !master_waitrequest;
    // Returns arriving after an abort (inflight cleared) are dropped.
    assign push      = master_readdatavalid && busy && (inflight != '0);
    assign pop       = wr_acc && !mode_fill;

    assign can_wr = ((state == S_RUN) || (state == S_DRAIN)) && (wr_left != '0)
                    && (mode_fill || (fifo_count != '0));
    assign can_rd = (state == S_RUN) && !mode_fill && (rd_left != '0)
                    && ((SUM_W'(inflight) + SUM_W'(fifo_count)) < SUM_W'(FIFO_DEPTH));
    // New commands launch only from an empty command slot; writes win.
    assign issue_wr = !cmd_pend && can_wr;
    assign issue_rd = !cmd_pend && !can_wr && can_rd;

    assign slave_waitrequest = !rst_n || (slave_read && (slave_address == A_CTRL) && busy);

    // Zero-wait register readback.
    always_comb begin
        slave_readdata = '0;
        if (slave_read && !slave_waitrequest) begin
            case (slave_address)
                A_CTRL:   slave_readdata = ctrl;
                A_DEST:   slave_readdata = dest;
                A_SRC:    slave_readdata = src;
                A_COUNT:  slave_readdata = count;
                A_STATUS: slave_readdata = DATA_W'({done, busy});
                A_FILL:   slave_readdata = fill;
                A_IRQEN:  slave_readdata = irqen;
                default:  slave_readdata = '0;
            endcase
        end
    end

    always_comb begin
        done_nxt  = done;
        irqen_nxt = irqen;
        if (state == S_DONE) done_nxt = 1'b1;
        if (slave_write && (slave_address == A_STATUS) && slave_writedata[1]) done_nxt = 1'b0;
        if (start) done_nxt = 1'b0;
        if (cfg_wr && (slave_address == A_IRQEN)) irqen_nxt = slave_writedata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (rd_left == '0) state_nxt = S_DRAIN;
            S_DRAIN: if ((wr_left == '0) && !cmd_pend) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[fifo_wr_ptr] <= master_readdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl             <= '0;
            dest             <= '0;
            src              <= '0;
            count            <= '0;
            fill             <= '0;
            irqen            <= '0;
            done             <= 1'b0;
            irq              <= 1'b0;
            rd_addr          <= '0;
            wr_addr          <= '0;
            rd_left          <= '0;
            wr_left          <= '0;
            inflight         <= '0;
            fifo_count       <= '0;
            fifo_rd_ptr      <= '0;
            fifo_wr_ptr      <= '0;
            master_address   <= '0;
            master_read      <= 1'b0;
            master_write     <= 1'b0;
            master_writedata <= '0;
        end else begin
            if (cfg_wr) begin
                case (slave_address)
                    A_DEST:  dest  <= slave_writedata;
                    A_SRC:   src   <= slave_writedata;
                    A_COUNT: count <= slave_writedata;
                    A_FILL:  fill  <= slave_writedata;
                    default: ;
                endcase
            end
            irqen <= irqen_nxt;
            done  <= done_nxt;
            irq   <= done_nxt & irqen_nxt[0];

            if (rd_acc) begin
                master_read <= 1'b0;
                rd_addr     <= rd_addr + STEP;
                rd_left     <= rd_left - DATA_W'(1);
            end
            if (wr_acc) begin
                master_write <= 1'b0;
                wr_addr      <= wr_addr + STEP;
                wr_left      <= wr_left - DATA_W'(1);
            end
            if (issue_wr) begin
                master_write     <= 1'b1;
                master_address   <= wr_addr;
                master_writedata <= mode_fill ? fill : fifo_mem[fifo_rd_ptr];
            end else if (issue_rd) begin
                master_read    <= 1'b1;
                master_address <= rd_addr;
            end

            inflight   <= inflight + CNT_W'(rd_acc) - CNT_W'(push);
            fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
            if (push) fifo_wr_ptr <= fifo_wr_ptr + PTR_W'(1);
            if (pop)  fifo_rd_ptr <= fifo_rd_ptr + PTR_W'(1);

            // Fill mode never reads, so its read counter starts exhausted.
            if (start) begin
                ctrl     <= slave_writedata;
                rd_addr  <= ADDR_W'(src);
                wr_addr  <= ADDR_W'(dest);
                rd_left  <= slave_writedata[0] ? '0 : count;
                wr_left  <= count;
                inflight <= '0;
            end
        end
    end

endmodule

// File: tb/tb_wordcopy_pipe.sv
// Directed bench for wordcopy_pipe: slave programming, memory responder,
// write monitor and immediate-assertion checks.
module tb_wordcopy_pipe;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DEPTH  = 8;

    localparam logic [3:0] A_CTRL   = 4'd0;
    localparam logic [3:0] A_DEST   = 4'd1;
    localparam logic [3:0] A_SRC    = 4'd2;
    localparam logic [3:0] A_COUNT  = 4'd3;
    localparam logic [3:0] A_STATUS = 4'd4;
    localparam logic [3:0] A_FILL   = 4'd5;
    localparam logic [3:0] A_IRQEN  = 4'd6;

    logic              clk;
    logic              rst_n;
    logic [3:0]        slave_address;
    logic              slave_read;
    logic              slave_write;
    logic [DATA_W-1:0] slave_writedata;
    logic [DATA_W-1:0] slave_readdata;
    logic              slave_waitrequest;
    logic [ADDR_W-1:0] master_address;
    logic              master_read;
    logic              master_write;
    logic [DATA_W-1:0] master_writedata;
    logic              master_waitrequest;
    logic [DATA_W-1:0] master_readdata;
    logic              master_readdatavalid;
    logic              irq;

    wordcopy_pipe #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .slave_address       (slave_address),
        .slave_read          (slave_read),
        .slave_write         (slave_write),
        .slave_writedata     (slave_writedata),
        .slave_readdata      (slave_readdata),
        .slave_waitrequest   (slave_waitrequest),
        .master_address      (master_address),
        .master_read         (master_read),
        .master_write        (master_write),
        .master_writedata    (master_writedata),
        .master_waitrequest  (master_waitrequest),
        .master_readdata     (master_readdata),
        .master_readdatavalid(master_readdatavalid),
        .irq                 (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rsp_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          lat     = 3;
    logic [31:0] data_base = '0;
    logic [31:0] src_base  = '0;
    logic        fill_mode_tb = 1'b0;
    rsp_t        rsp_q[$];
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    int          outst = 0, occ = 0, max_out = 0, ovf = 0;
    int          rd_seen = 0, viol = 0, stall_seen = 0;

    // Monitor: memory-side accept tracking, write capture, hold-stable check.
    initial begin
        logic        prev_pend;
        logic        prev_r, prev_w;
        logic [31:0] prev_a, prev_d;
        rsp_t        r;
        prev_pend = 1'b0;
        prev_r = 1'b0; prev_w = 1'b0; prev_a = '0; prev_d = '0;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                outst = 0;
                occ = 0;
                prev_pend = 1'b0;
            end else begin
                if (master_read) rd_seen++;
                if (prev_pend && (master_read !== prev_r || master_write !== prev_w ||
                                  master_address !== prev_a ||
                                  (master_write && master_writedata !== prev_d)))
                    viol++;
                prev_pend = (master_read || master_write) && master_waitrequest;
                if (prev_pend) stall_seen++;
                prev_r = master_read;
                prev_w = master_write;
                prev_a = master_address;
                prev_d = master_writedata;
                if (master_readdatavalid && outst > 0) begin
                    outst--;
                    occ++;
                    if (occ > int'(DEPTH)) ovf++;
                end
                if (master_write && !master_waitrequest) begin
                    wa_q.push_back(master_address);
                    wd_q.push_back(master_writedata);
                    if (!fill_mode_tb && occ > 0) occ--;
                end
                if (master_read && !master_waitrequest) begin
                    r.due  = cyc + lat;
                    r.data = data_base + ((master_address - src_base) >> 2);
                    rsp_q.push_back(r);
                    outst++;
                    if (outst > max_out) max_out = outst;
                end
            end
        end
    end

    // Responder: returns read data in order after a fixed latency.
    initial begin
        master_readdatavalid = 1'b0;
        master_readdata      = '0;
        forever begin
            @(negedge clk);
            if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
                master_readdatavalid = 1'b1;
                master_readdata      = rsp_q[0].data;
                void'(rsp_q.pop_front());
            end else begin
                master_readdatavalid = 1'b0;
                master_readdata      = '0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reg_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        slave_address   = a;
        slave_writedata = d;
        slave_write     = 1'b1;
        @(negedge clk);
        slave_write     = 1'b0;
    endtask

    task automatic reg_read(input logic [3:0] a, output logic [31:0] d, output int waits);
        @(negedge clk);
        slave_address = a;
        slave_read    = 1'b1;
        waits         = 0;
        #1;
        while (slave_waitrequest && waits < 400) begin
            @(negedge clk);
            #1;
            waits++;
        end
        d          = slave_readdata;
        slave_read = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        logic [31:0] s;
        int          w;
        int          n;
        n = 0;
        do begin
            reg_read(A_STATUS, s, w);
            n++;
        end while (s[0] && n < 500);
        check({tag, "_idle"}, 32'(s[0]), 32'd0);
    endtask

    task automatic check_writes(input string tag, input int n, input logic [31:0] a0,
                                input logic [31:0] d0, input logic [31:0] dstep);
        check({tag, "_nwr"}, 32'(wa_q.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (i < wa_q.size()) begin
                check($sformatf("%s_addr%0d", tag, i), wa_q[i], a0 + 32'(4 * i));
                check($sformatf("%s_data%0d", tag, i), wd_q[i], d0 + dstep * 32'(i));
            end else begin
                check($sformatf("%s_missing%0d", tag, i), 32'(wa_q.size()), 32'(n));
            end
        end
    endtask

    initial begin
        logic [31:0] rd;
        int          w;
        int          n;

        rst_n = 1'b0;
        slave_address = '0;
        slave_read = 1'b0;
        slave_write = 1'b0;
        slave_writedata = '0;
        master_waitrequest = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_mread", 32'(master_read), 32'd0);
        check("rst_mwrite", 32'(master_write), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_swait", 32'(slave_waitrequest), 32'd1);
        rst_n = 1'b1;
        #1;
        check("rel_swait", 32'(slave_waitrequest), 32'd0);
        reg_read(A_STATUS, rd, w);
        check("rst_status", rd, 32'd0);
        reg_read(A_CTRL, rd, w);
        check("rst_ctrl", rd, 32'd0);

        // 1: basic copy, CTRL read stalls until finished
        data_base = 32'h25; src_base = 32'h13; lat = 3; fill_mode_tb = 1'b0;
        wa_q.delete(); wd_q.delete();
        reg_write(A_DEST, 32'h12);
        reg_write(A_SRC, 32'h13);
        reg_write(A_COUNT, 32'd3);
        reg_write(A_CTRL, 32'hAA);
        reg_read(A_CTRL, rd, w);
        check("t1_ctrl_stalled", 32'(w > 0), 32'd1);
        check("t1_ctrl_bounded", 32'(w < 400), 32'd1);
        check("t1_ctrl_val", rd, 32'hAA);
        reg_read(A_STATUS, rd, w);
        check("t1_status", rd, 32'd2);
        check_writes("t1", 3, 32'h12, 32'h25, 32'd1);

        // 2: pipelined copy; config writes while busy are ignored
        data_base = 32'h1000; src_base = 32'h200; lat = 4;
        max_out = 0; ovf = 0;
        wa_q.delete(); wd_q.delete();
        reg_write(A_DEST, 32'h400);
        reg_write(A_SRC, 32'h200);
        reg_write(A_COUNT, 32'd12);
        reg_write(A_CTRL, 32'h0);
        reg_write(A_DEST, 32'hFFFF);
        reg_write(A_CTRL, 32'h55);
        wait_idle("t2");
        check_writes("t2", 12, 32'h400, 32'h1000, 32'd1);
        check("t2_max_outstanding", 32'(max_out <= int'(DEPTH)), 32'd1);
        check("t2_overflow", 32'(ovf), 32'd0);
        reg_read(A_DEST, rd, w);
        check("t2_dest_kept", rd, 32'h400);
        reg_read(A_CTRL, rd, w);
        check("t2_ctrl_kept", rd, 32'h0);

        // 3: fill mode, no reads
        fill_mode_tb = 1'b1; rd_seen = 0;
        wa_q.delete(); wd_q.delete();
        reg_write(A_FILL, 32'hDEADBEEF);
        reg_write(A_DEST, 32'h100);
        reg_write(A_COUNT, 32'd4);
        reg_write(A_CTRL, 32'h1);
        wait_idle("t3");
        check_writes("t3", 4, 32'h100, 32'hDEADBEEF, 32'd0);
        check("t3_no_reads", 32'(rd_seen), 32'd0);
        reg_read(A_FILL, rd, w);
        check("t3_fill_rb", rd, 32'hDEADBEEF);

        // 4: master backpressure mid-copy
        fill_mode_tb = 1'b0; data_base = 32'h77; src_base = 32'h300; lat = 2;
        viol = 0; stall_seen = 0;
        wa_q.delete(); wd_q.delete();
        reg_write(A_DEST, 32'h500);
        reg_write(A_SRC, 32'h300);
        reg_write(A_COUNT, 32'd6);
        reg_write(A_CTRL, 32'h0);
        repeat (5) @(negedge clk);
        master_waitrequest = 1'b1;
        repeat (5) @(negedge clk);
        master_waitrequest = 1'b0;
        wait_idle("t4");
        check_writes("t4", 6, 32'h500, 32'h77, 32'd1);
        check("t4_held_stable", 32'(viol), 32'd0);
        check("t4_stall_hit", 32'(stall_seen > 0), 32'd1);

        // 5: zero count, status and interrupt
        rd_seen = 0;
        wa_q.delete(); wd_q.delete();
        reg_write(A_IRQEN, 32'h1);
        reg_write(A_COUNT, 32'd0);
        reg_write(A_CTRL, 32'h0);
        n = 0;
        while (!irq && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("t5_irq_set", 32'(irq), 32'd1);
        check("t5_irq_latency", 32'(n <= 3), 32'd1);
        reg_read(A_STATUS, rd, w);
        check("t5_status_done", rd, 32'd2);
        check("t5_no_writes", 32'(wa_q.size()), 32'd0);
        check("t5_no_reads", 32'(rd_seen), 32'd0);
        reg_write(A_STATUS, 32'h2);
        check("t5_irq_clear", 32'(irq), 32'd0);
        reg_read(A_STATUS, rd, w);
        check("t5_status_clear", rd, 32'd0);
        reg_write(A_IRQEN, 32'h0);
        reg_write(A_CTRL, 32'h0);
        wait_idle("t5b");
        reg_read(A_STATUS, rd, w);
        check("t5_masked_done", rd, 32'd2);
        check("t5_masked_irq", 32'(irq), 32'd0);
        reg_write(A_STATUS, 32'h2);

        // 6: reset mid-copy, then a clean copy proves the FIFO was flushed
        data_base = 32'h900; src_base = 32'h600; lat = 4;
        reg_write(A_IRQEN, 32'h1);
        reg_write(A_DEST, 32'h700);
        reg_write(A_SRC, 32'h600);
        reg_write(A_COUNT, 32'd8);
        reg_write(A_CTRL, 32'h0);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6_mread_drop", 32'(master_read), 32'd0);
        check("t6_mwrite_drop", 32'(master_write), 32'd0);
        check("t6_swait_rst", 32'(slave_waitrequest), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wa_q.delete(); wd_q.delete(); rd_seen = 0;
        repeat (8) @(negedge clk);
        reg_read(A_STATUS, rd, w);
        check("t6_status", rd, 32'd0);
        reg_read(A_DEST, rd, w);
        check("t6_dest_cleared", rd, 32'd0);
        reg_read(A_IRQEN, rd, w);
        check("t6_irqen_cleared", rd, 32'd0);
        check("t6_no_writes", 32'(wa_q.size()), 32'd0);
        check("t6_no_reads", 32'(rd_seen), 32'd0);
        data_base = 32'hA0; src_base = 32'h40;
        reg_write(A_DEST, 32'h80);
        reg_write(A_SRC, 32'h40);
        reg_write(A_COUNT, 32'd2);
        reg_write(A_CTRL, 32'h0);
        wait_idle("t6");
        check_writes("t6", 2, 32'h80, 32'hA0, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
